// File: rtl/data_memory_responder_if.sv
// ============================================================================
// Module   : data_memory_responder_if
// Purpose  : Core-to-RAM data-memory handshake bundle (load and store channels)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_memory_responder_if;
  logic        loadRequest;
  logic [31:0] loadAddress;
  logic [31:0] loadData;
  logic        loadDataValid;
  logic        storeValid;
  logic [31:0] storeAddress;
  logic [31:0] storeData;
  logic [3:0]  storeByteEnable;
  logic        storeComplete;
  logic        busy;

  modport master (
    output loadRequest, loadAddress, storeValid, storeAddress, storeData, storeByteEnable,
    input  loadData, loadDataValid, storeComplete, busy
  );

  modport slave (
    input  loadRequest, loadAddress, storeValid, storeAddress, storeData, storeByteEnable,
    output loadData, loadDataValid, storeComplete, busy
  );
endinterface

`default_nettype wire

// File: rtl/data_memory_responder.sv
// ============================================================================
// Module   : data_memory_responder
// Purpose  : Word-organised on-chip RAM serving core loads and byte-enabled
//            stores with configurable response latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory_responder #(
  parameter int MEMORY_BYTES  = 65536,
  parameter int LOAD_LATENCY  = 1,
  parameter int STORE_LATENCY = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  data_memory_responder_if.slave   dmem
);

  localparam int         c_addr_bits  = $clog2(MEMORY_BYTES);
  localparam int         c_words      = MEMORY_BYTES / 4;
  localparam logic [3:0] c_load_init  = 4'(LOAD_LATENCY - 1);
  localparam logic [3:0] c_store_init = 4'(STORE_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_WAIT  = 2'd1,
    STORE_WAIT = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_count;
  logic [31:2] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_mem [c_words];

  logic [c_addr_bits-3:0] w_index;
  logic                   w_in_range;
  logic                   w_commit;
  logic                   w_unused;

  assign w_index    = r_addr[c_addr_bits-1:2];
  assign w_in_range = (r_addr[31:c_addr_bits] == '0);
  // Commit is suppressed while reset is high so a cancelled store never lands.
  assign w_commit   = (r_state == STORE_WAIT) && (r_count == 4'd0) && !reset;
  assign w_unused   = ^{dmem.loadAddress[1:0], dmem.storeAddress[1:0]};

  always_ff @(posedge clock) begin
    if (w_commit && w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) begin
          r_mem[w_index][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state            <= IDLE;
      r_count            <= 4'd0;
      dmem.loadData      <= 32'd0;
      dmem.loadDataValid <= 1'b0;
      dmem.storeComplete <= 1'b0;
      dmem.busy          <= 1'b0;
    end else begin
      dmem.loadDataValid <= 1'b0;
      dmem.storeComplete <= 1'b0;
      case (r_state)
        IDLE: begin
          if (dmem.storeValid) begin
            r_addr    <= dmem.storeAddress[31:2];
            r_wdata   <= dmem.storeData;
            r_be      <= dmem.storeByteEnable;
            r_count   <= c_store_init;
            r_state   <= STORE_WAIT;
            dmem.busy <= 1'b1;
          end else if (dmem.loadRequest) begin
            r_addr    <= dmem.loadAddress[31:2];
            r_count   <= c_load_init;
            r_state   <= LOAD_WAIT;
            dmem.busy <= 1'b1;
          end
        end
        LOAD_WAIT: begin
          // A dropped request means the core flushed the load.
          if (!dmem.loadRequest) begin
            r_state   <= IDLE;
            dmem.busy <= 1'b0;
          end else if (r_count == 4'd0) begin
            dmem.loadData      <= w_in_range ? r_mem[w_index] : 32'd0;
            dmem.loadDataValid <= 1'b1;
            r_state            <= IDLE;
            dmem.busy          <= 1'b0;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        STORE_WAIT: begin
          if (r_count == 4'd0) begin
            dmem.storeComplete <= 1'b1;
            r_state            <= IDLE;
            dmem.busy          <= 1'b0;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        default: begin
          r_state   <= IDLE;
          dmem.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_memory_responder.sv
// ============================================================================
// Module   : tb_data_memory_responder
// Purpose  : Self-checking bench; dut_a uses 1/1 latency, dut_b uses 3/4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_memory_responder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  data_memory_responder_if ifa();
  data_memory_responder_if ifb();

  data_memory_responder #(.MEMORY_BYTES(65536), .LOAD_LATENCY(1), .STORE_LATENCY(1)) dut_a (
    .clock (clock), .reset (reset), .dmem (ifa));
  data_memory_responder #(.MEMORY_BYTES(65536), .LOAD_LATENCY(3), .STORE_LATENCY(4)) dut_b (
    .clock (clock), .reset (reset), .dmem (ifb));

  int vectors    = 0;
  int miscompares = 0;
  logic [31:0] exp_q [$];

  function automatic logic get_ldv(input int s);
    return (s == 0) ? ifa.loadDataValid : ifb.loadDataValid;
  endfunction
  function automatic logic [31:0] get_ld(input int s);
    return (s == 0) ? ifa.loadData : ifb.loadData;
  endfunction
  function automatic logic get_sc(input int s);
    return (s == 0) ? ifa.storeComplete : ifb.storeComplete;
  endfunction
  function automatic logic get_busy(input int s);
    return (s == 0) ? ifa.busy : ifb.busy;
  endfunction

  task automatic set_load(input int s, input logic r, input logic [31:0] a);
    if (s == 0) begin ifa.loadRequest = r; ifa.loadAddress = a; end
    else        begin ifb.loadRequest = r; ifb.loadAddress = a; end
  endtask

  task automatic set_store(input int s, input logic v, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be);
    if (s == 0) begin ifa.storeValid = v; ifa.storeAddress = a; ifa.storeData = d; ifa.storeByteEnable = be; end
    else        begin ifb.storeValid = v; ifb.storeAddress = a; ifb.storeData = d; ifb.storeByteEnable = be; end
  endtask

  // Latency is counted in edges after the acceptance edge (iteration 0).
  task automatic run_load(input int s, input logic [31:0] a,
                          output logic [31:0] d, output int lat, output bit seen);
    set_load(s, 1'b1, a);
    seen = 1'b0; lat = -1; d = 32'd0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clock); #1;
      if (get_ldv(s)) begin seen = 1'b1; lat = i; d = get_ld(s); end
    end
    set_load(s, 1'b0, a);
  endtask

  task automatic run_store(input int s, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, output int lat, output bit seen);
    set_store(s, 1'b1, a, d, be);
    seen = 1'b0; lat = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clock); #1;
      if (get_sc(s)) begin seen = 1'b1; lat = i; end
    end
    set_store(s, 1'b0, a, d, be);
  endtask

  task automatic test_reset;
    set_load(0, 1'b0, 32'd0); set_load(1, 1'b0, 32'd0);
    set_store(0, 1'b0, 32'd0, 32'd0, 4'd0); set_store(1, 1'b0, 32'd0, 32'd0, 4'd0);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if ({get_ldv(s), get_sc(s), get_busy(s)} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_flags dut%0d: got %b expected 000", s, {get_ldv(s), get_sc(s), get_busy(s)});
      end
      vectors++;
      if (get_ld(s) !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_loadData dut%0d: got %h expected 00000000", s, get_ld(s));
      end
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_store_load;
    logic [31:0] d, e; int lat; bit seen;
    run_store(0, 32'h100, 32'hDEADBEEF, 4'b1111, lat, seen);
    vectors++;
    if (!seen || lat !== 1) begin
      miscompares++;
      $display("FAIL store_latency: got seen=%0d lat=%0d expected seen=1 lat=1", seen, lat);
    end
    exp_q.push_back(32'hDEADBEEF);
    run_load(0, 32'h100, d, lat, seen);
    e = exp_q.pop_front();
    vectors++;
    if (!seen || lat !== 1 || d !== e) begin
      miscompares++;
      $display("FAIL load_after_store: got seen=%0d lat=%0d data=%h expected seen=1 lat=1 data=%h", seen, lat, d, e);
    end
  endtask

  task automatic test_byte_merge;
    logic [31:0] d, e; int lat; bit seen;
    run_store(0, 32'h104, 32'h11223344, 4'b1111, lat, seen);
    run_store(0, 32'h105, 32'h0000AA00, 4'b0010, lat, seen);
    exp_q.push_back(32'h1122AA44);
    run_load(0, 32'h104, d, lat, seen);
    e = exp_q.pop_front();
    vectors++;
    if (!seen || d !== e) begin
      miscompares++;
      $display("FAIL byte_merge_0010: got seen=%0d data=%h expected %h", seen, d, e);
    end
    run_store(0, 32'h104, 32'hBB0000CC, 4'b1001, lat, seen);
    exp_q.push_back(32'hBB22AACC);
    run_load(0, 32'h107, d, lat, seen);
    e = exp_q.pop_front();
    vectors++;
    if (!seen || d !== e) begin
      miscompares++;
      $display("FAIL byte_merge_1001: got seen=%0d data=%h expected %h", seen, d, e);
    end
  endtask

  task automatic test_latency;
    logic [31:0] d, e; int lat; bit seen; int pulses;
    run_store(1, 32'h100, 32'hA5A55A5A, 4'b1111, lat, seen);
    vectors++;
    if (!seen || lat !== 4) begin
      miscompares++;
      $display("FAIL store_latency4: got seen=%0d lat=%0d expected seen=1 lat=4", seen, lat);
    end
    exp_q.push_back(32'hA5A55A5A);
    set_load(1, 1'b1, 32'h100);
    pulses = 0; d = 32'd0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clock); #1;
      vectors++;
      if (get_ldv(1) !== (i == 3)) begin
        miscompares++;
        $display("FAIL latency3_valid edge%0d: got %b expected %b", i, get_ldv(1), (i == 3));
      end
      vectors++;
      if (get_busy(1) !== (i < 3)) begin
        miscompares++;
        $display("FAIL latency3_busy edge%0d: got %b expected %b", i, get_busy(1), (i < 3));
      end
      if (get_ldv(1)) begin pulses++; d = get_ld(1); set_load(1, 1'b0, 32'h100); end
    end
    set_load(1, 1'b0, 32'h100);
    e = exp_q.pop_front();
    vectors++;
    if (pulses !== 1 || d !== e) begin
      miscompares++;
      $display("FAIL latency3_data: got pulses=%0d data=%h expected pulses=1 data=%h", pulses, d, e);
    end
  endtask

  task automatic test_flush;
    logic [31:0] d, e; int lat; bit seen; int pulses;
    set_load(1, 1'b1, 32'h100);
    @(posedge clock); #1;
    vectors++;
    if (get_busy(1) !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_accept_busy: got %b expected 1", get_busy(1));
    end
    set_load(1, 1'b0, 32'h100);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (get_ldv(1)) pulses++;
    end
    vectors++;
    if (pulses !== 0 || get_busy(1) !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_abort: got pulses=%0d busy=%b expected pulses=0 busy=0", pulses, get_busy(1));
    end
    exp_q.push_back(32'hA5A55A5A);
    run_load(1, 32'h100, d, lat, seen);
    e = exp_q.pop_front();
    vectors++;
    if (!seen || lat !== 3 || d !== e) begin
      miscompares++;
      $display("FAIL flush_reload: got seen=%0d lat=%0d data=%h expected seen=1 lat=3 data=%h", seen, lat, d, e);
    end
  endtask

  task automatic test_simultaneous;
    logic [31:0] d; logic [7:0] e; int sc_at, ld_at;
    sc_at = -1; ld_at = -1; d = 32'd0;
    exp_q.push_back(32'h00000055);
    set_store(0, 1'b1, 32'h200, 32'h00000055, 4'b0001);
    set_load(0, 1'b1, 32'h200);
    for (int i = 0; i < 20 && ld_at < 0; i++) begin
      @(posedge clock); #1;
      if (get_sc(0) && sc_at < 0) begin sc_at = i; set_store(0, 1'b0, 32'h200, 32'd0, 4'd0); end
      if (get_ldv(0)) begin ld_at = i; d = get_ld(0); set_load(0, 1'b0, 32'h200); end
    end
    set_store(0, 1'b0, 32'h200, 32'd0, 4'd0);
    set_load(0, 1'b0, 32'h200);
    vectors++;
    if (sc_at !== 1 || ld_at !== 3) begin
      miscompares++;
      $display("FAIL simultaneous_order: got store_at=%0d load_at=%0d expected store_at=1 load_at=3", sc_at, ld_at);
    end
    e = exp_q.pop_front() & 32'hFF;
    vectors++;
    if (d[7:0] !== e) begin
      miscompares++;
      $display("FAIL simultaneous_data: got low byte %h expected %h", d[7:0], e);
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] d, e; int lat; bit seen;
    exp_q.push_back(32'h00000000);
    run_load(0, 32'h00010000, d, lat, seen);
    e = exp_q.pop_front();
    vectors++;
    if (!seen || lat !== 1 || d !== e) begin
      miscompares++;
      $display("FAIL oor_load_10000: got seen=%0d lat=%0d data=%h expected seen=1 lat=1 data=%h", seen, lat, d, e);
    end
    exp_q.push_back(32'h00000000);
    run_load(0, 32'hFFFFFFFC, d, lat, seen);
    e = exp_q.pop_front();
    vectors++;
    if (!seen || d !== e) begin
      miscompares++;
      $display("FAIL oor_load_top: got seen=%0d data=%h expected %h", seen, d, e);
    end
    run_store(0, 32'h00010100, 32'h0BAD0BAD, 4'b1111, lat, seen);
    vectors++;
    if (!seen || lat !== 1) begin
      miscompares++;
      $display("FAIL oor_store_pulse: got seen=%0d lat=%0d expected seen=1 lat=1", seen, lat);
    end
    exp_q.push_back(32'hDEADBEEF);
    run_load(0, 32'h100, d, lat, seen);
    e = exp_q.pop_front();
    vectors++;
    if (!seen || d !== e) begin
      miscompares++;
      $display("FAIL oor_store_no_alias: got seen=%0d data=%h expected %h", seen, d, e);
    end
  endtask

  task automatic test_reset_store;
    logic [31:0] d, e; int lat; bit seen; int pulses;
    run_store(1, 32'h300, 32'hCAFEF00D, 4'b1111, lat, seen);
    set_store(1, 1'b1, 32'h300, 32'h12345678, 4'b1111);
    @(posedge clock); #1;
    @(posedge clock); #1;
    set_store(1, 1'b0, 32'h300, 32'h12345678, 4'b1111);
    reset = 1'b1;
    @(posedge clock); #1;
    vectors++;
    if (get_sc(1) !== 1'b0 || get_busy(1) !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_store_cancel: got complete=%b busy=%b expected 0 0", get_sc(1), get_busy(1));
    end
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (get_sc(1)) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL reset_store_nopulse: got %0d pulses expected 0", pulses);
    end
    exp_q.push_back(32'hCAFEF00D);
    run_load(1, 32'h300, d, lat, seen);
    e = exp_q.pop_front();
    vectors++;
    if (!seen || d !== e) begin
      miscompares++;
      $display("FAIL reset_store_unchanged: got seen=%0d data=%h expected %h", seen, d, e);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_merge();
    test_latency();
    test_flush();
    test_simultaneous();
    test_out_of_range();
    test_reset_store();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
